// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer: entry layout,
// capture state encoding and register-address width.
package trace_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int TRACE_XLEN = 32;
  localparam int TS_WIDTH   = 32;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] instruction;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd_address;
    logic [TRACE_XLEN-1:0] write_data;
    logic [TS_WIDTH-1:0]   timestamp;
  } trace_entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } trace_state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's level counter.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired instructions into a circular trace buffer, stops capture on
// the halt encoding, and replays entries over a valid/ready stream.
// Optional per-entry cycle stamps are built when TRACE_TIMESTAMP_EN is defined.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 16,
  parameter logic [XLEN-1:0]  HALT_INSN = '0,
  parameter bit               OVERWRITE = 1'b0,
  localparam int              PTR_W     = $clog2(DEPTH),
  localparam int              LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  commit_valid,
  input  logic [XLEN-1:0]       commit_pc,
  input  logic [XLEN-1:0]       commit_instruction,
  input  logic                  commit_reg_write,
  input  logic [REG_ADDR_W-1:0] commit_rd_address,
  input  logic [XLEN-1:0]       commit_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_instruction,
  output logic [XLEN-1:0]       out_write_data,
  output logic                  out_reg_write,
  output logic [REG_ADDR_W-1:0] out_rd_address,
  output logic [31:0]           out_timestamp,
  output logic                  halted,
  output logic [LVL_W-1:0]      level,
  output logic [15:0]           dropped_count,
  output logic [31:0]           commit_count
);

  // Stream handshake: an entry leaves when out_valid && out_ready at a rising
  // edge; out_valid never depends on out_ready, and the head fields stay put
  // until the entry is accepted.

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = TS_WIDTH;
`else
  localparam int TS_W = 0;
`endif
  localparam int STORE_W = 3 * XLEN + 1 + REG_ADDR_W + TS_W;
  localparam int WD_OFF  = TS_W;
  localparam int RD_OFF  = WD_OFF + XLEN;
  localparam int RW_OFF  = RD_OFF + REG_ADDR_W;
  localparam int IN_OFF  = RW_OFF + 1;
  localparam int PC_OFF  = IN_OFF + XLEN;

  trace_state_e state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             valid_q, valid_d;
  logic [15:0]      dropped_q, dropped_d;
  logic [31:0]      commits_q, commits_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]      cycle_q, cycle_d;
`endif

  logic               ram_we;
  logic [STORE_W-1:0] ram_wdata, ram_rdata;
  logic               full, pop, push_req, store_new, overwrite_old;
  trace_entry_t       head;

`ifdef TRACE_TIMESTAMP_EN
  assign ram_wdata = {commit_pc, commit_instruction, commit_reg_write,
                      commit_rd_address, commit_write_data, cycle_q};
`else
  assign ram_wdata = {commit_pc, commit_instruction, commit_reg_write,
                      commit_rd_address, commit_write_data};
`endif

  trace_ram #(.DEPTH(DEPTH), .WIDTH(STORE_W)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    dropped_d = dropped_q;
    commits_d = commits_q;
    ram_we    = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
    cycle_d   = cycle_q + 32'd1;
`endif

    full          = (level_q == LVL_W'(DEPTH));
    pop           = valid_q && out_ready;
    push_req      = commit_valid && (state_q == ST_RUN);
    // A pop in the same cycle frees a slot, so a full buffer still takes the push.
    store_new     = push_req && (!full || pop);
    overwrite_old = push_req && full && !pop && OVERWRITE;

    if (store_new || overwrite_old) begin
      ram_we    = 1'b1;
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      commits_d = (commits_q == '1) ? commits_q : commits_q + 32'd1;
    end
    if (push_req && full && !pop) begin
      dropped_d = (dropped_q == '1) ? dropped_q : dropped_q + 16'd1;
    end
    if (pop || overwrite_old) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (store_new && !pop)      level_d = level_q + LVL_W'(1);
    else if (!store_new && pop) level_d = level_q - LVL_W'(1);

    if (push_req && (commit_instruction == HALT_INSN)) state_d = ST_HALTED;

    if (clear) begin
      state_d   = ST_RUN;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      dropped_d = '0;
      commits_d = '0;
      ram_we    = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      cycle_d   = '0;
`endif
    end

    valid_d = (level_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      dropped_q <= '0;
      commits_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      commits_q <= commits_d;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q   <= cycle_d;
`endif
    end
  end

  // Head fields read zero whenever the buffer is empty, so stale RAM never leaks out.
  always_comb begin
    head = '0;
    if (valid_q) begin
      head.pc          = TRACE_XLEN'(ram_rdata[PC_OFF +: XLEN]);
      head.instruction = TRACE_XLEN'(ram_rdata[IN_OFF +: XLEN]);
      head.reg_write   = ram_rdata[RW_OFF];
      head.rd_address  = ram_rdata[RD_OFF +: REG_ADDR_W];
      head.write_data  = TRACE_XLEN'(ram_rdata[WD_OFF +: XLEN]);
`ifdef TRACE_TIMESTAMP_EN
      head.timestamp   = ram_rdata[0 +: TS_WIDTH];
`endif
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = head.pc[XLEN-1:0];
  assign out_instruction = head.instruction[XLEN-1:0];
  assign out_write_data  = head.write_data[XLEN-1:0];
  assign out_reg_write   = head.reg_write;
  assign out_rd_address  = head.rd_address;
  assign out_timestamp   = head.timestamp;
  assign halted          = (state_q == ST_HALTED);
  assign level           = level_q;
  assign dropped_count   = dropped_q;
  assign commit_count    = commits_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: two DEPTH=4 instances share stimulus,
// one dropping incoming commits when full, the other overwriting the oldest.
module tb_commit_trace_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_instruction = '0;
  logic        commit_reg_write = 1'b0;
  logic [4:0]  commit_rd_address = '0;
  logic [31:0] commit_write_data = '0;
  logic        out_ready = 1'b0;

  logic        out_valid_a, out_valid_b, out_reg_write_a, out_reg_write_b;
  logic [31:0] out_pc_a, out_pc_b, out_insn_a, out_insn_b, out_wd_a, out_wd_b;
  logic [4:0]  out_rd_a, out_rd_b;
  logic [31:0] out_ts_a, out_ts_b;
  logic        halted_a, halted_b;
  logic [2:0]  level_a, level_b;
  logic [15:0] dropped_a, dropped_b;
  logic [31:0] commits_a, commits_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clock = ~clock;

  commit_trace_buffer #(.XLEN(32), .DEPTH(4), .HALT_INSN(32'h0), .OVERWRITE(1'b0)) dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instruction(commit_instruction), .commit_reg_write(commit_reg_write),
    .commit_rd_address(commit_rd_address), .commit_write_data(commit_write_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
    .out_instruction(out_insn_a), .out_write_data(out_wd_a),
    .out_reg_write(out_reg_write_a), .out_rd_address(out_rd_a),
    .out_timestamp(out_ts_a), .halted(halted_a), .level(level_a),
    .dropped_count(dropped_a), .commit_count(commits_a)
  );

  commit_trace_buffer #(.XLEN(32), .DEPTH(4), .HALT_INSN(32'h0), .OVERWRITE(1'b1)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instruction(commit_instruction), .commit_reg_write(commit_reg_write),
    .commit_rd_address(commit_rd_address), .commit_write_data(commit_write_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .out_instruction(out_insn_b), .out_write_data(out_wd_b),
    .out_reg_write(out_reg_write_b), .out_rd_address(out_rd_b),
    .out_timestamp(out_ts_b), .halted(halted_b), .level(level_b),
    .dropped_count(dropped_b), .commit_count(commits_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] wd);
    commit_valid       = 1'b1;
    commit_pc          = pc;
    commit_instruction = insn;
    commit_reg_write   = 1'b1;
    commit_rd_address  = pc[6:2];
    commit_write_data  = wd;
    @(posedge clock);
    #1 commit_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_pc_a"}, out_pc_a, exp_a_q.pop_front());
      check({tag, "_pc_b"}, out_pc_b, exp_b_q.pop_front());
      @(posedge clock);
      #1;
    end
    out_ready = 1'b0;
    check({tag, "_empty_a"}, {31'd0, out_valid_a}, 32'd0);
    check({tag, "_empty_b"}, {31'd0, out_valid_b}, 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},   {31'd0, out_valid_a}, 32'd0);
    check({tag, "_level"},   {29'd0, level_a}, 32'd0);
    check({tag, "_halted"},  {31'd0, halted_a}, 32'd0);
    check({tag, "_dropped"}, {16'd0, dropped_a}, 32'd0);
    check({tag, "_commits"}, commits_a, 32'd0);
    check({tag, "_pc"},      out_pc_a, 32'd0);
    check({tag, "_ts"},      out_ts_a, 32'd0);
  endtask

  task automatic fill_halted();
    do_commit(32'h20, NOP, 32'd1);
    do_commit(32'h24, NOP, 32'd2);
    do_commit(32'h28, 32'h0, 32'd3);
    check("pre_level", {29'd0, level_a}, 32'd3);
    check("pre_halted", {31'd0, halted_a}, 32'd1);
  endtask

  task automatic stamp_check(input string tag);
    repeat (5) @(posedge clock);
    #1;
    do_commit(32'h40, NOP, 32'd9);
`ifdef TRACE_TIMESTAMP_EN
    check(tag, out_ts_a, 32'd5);
`else
    check(tag, out_ts_a, 32'd0);
`endif
  endtask

  initial begin
    do_reset();
    check_idle("reset");

    // In-order replay with backpressure
    do_commit(32'h0, NOP, 32'h11);
    do_commit(32'h4, NOP, 32'h22);
    do_commit(32'h8, NOP, 32'h33);
    check("basic_level", {29'd0, level_a}, 32'd3);
    check("basic_valid", {31'd0, out_valid_a}, 32'd1);
    check("basic_wd", out_wd_a, 32'h11);
    @(posedge clock);
    #1;
    check("hold_pc", out_pc_a, 32'h0);
    check("basic_commits", commits_a, 32'd3);
    exp_a_q = '{32'h0, 32'h4, 32'h8};
    exp_b_q = '{32'h0, 32'h4, 32'h8};
    drain("basic", 3);

    // Overflow: drop-new versus overwrite-oldest
    do_clear();
    for (int i = 0; i < 6; i++) do_commit(32'h100 + 32'(4 * i), NOP, 32'(i));
    check("ovf_level_a", {29'd0, level_a}, 32'd4);
    check("ovf_drop_a", {16'd0, dropped_a}, 32'd2);
    check("ovf_commits_a", commits_a, 32'd4);
    check("ovf_level_b", {29'd0, level_b}, 32'd4);
    check("ovf_drop_b", {16'd0, dropped_b}, 32'd2);
    check("ovf_commits_b", commits_b, 32'd6);
    check("ovf_wd_b", out_wd_b, 32'd2);
    exp_a_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    exp_b_q = '{32'h108, 32'h10C, 32'h110, 32'h114};
    drain("ovf", 4);

    // Full buffer with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 4; i++) do_commit(32'h200 + 32'(4 * i), NOP, 32'(i));
    out_ready = 1'b1;
    check("pp_head_a", out_pc_a, 32'h200);
    do_commit(32'h210, NOP, 32'h99);
    out_ready = 1'b0;
    check("pp_level_a", {29'd0, level_a}, 32'd4);
    check("pp_drop_a", {16'd0, dropped_a}, 32'd0);
    check("pp_drop_b", {16'd0, dropped_b}, 32'd0);
    exp_a_q = '{32'h204, 32'h208, 32'h20C, 32'h210};
    exp_b_q = '{32'h204, 32'h208, 32'h20C, 32'h210};
    drain("pp", 4);

    // Halt detection stops capture
    do_clear();
    do_commit(32'hC, NOP, 32'd5);
    check("halt_pre", {31'd0, halted_a}, 32'd0);
    do_commit(32'h10, 32'h0, 32'd6);
    check("halt_set", {31'd0, halted_a}, 32'd1);
    do_commit(32'h14, NOP, 32'd7);
    do_commit(32'h18, NOP, 32'd8);
    check("halt_level", {29'd0, level_a}, 32'd2);
    check("halt_commits", commits_a, 32'd2);
    check("halt_insn", out_insn_a, NOP);
    exp_a_q = '{32'hC, 32'h10};
    exp_b_q = '{32'hC, 32'h10};
    drain("halt", 2);
    check("halt_stays", {31'd0, halted_a}, 32'd1);

    // Clear from a halted, partly filled buffer
    do_clear();
    fill_halted();
    do_clear();
    check_idle("clear");
    stamp_check("clear_ts");

    // Reset mid-operation
    do_clear();
    fill_halted();
    do_reset();
    check_idle("midreset");
    stamp_check("reset_ts");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
